// File: rtl/alu_nibble_seq_if.sv
// alu_nibble_seq_if
//   Request/response bundle for the nibble-serial ALU sequencer.
//   master: drives start, op, a, b; observes busy, done, result, c, n, z, v.
//   slave : the sequencer side (directions reversed).
//   NIBBLES sets the operand width W = 4*NIBBLES.
interface alu_nibble_seq_if #(
  parameter int unsigned NIBBLES = 4
) ();
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c;
  logic         n;
  logic         z;
  logic         v;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c, n, z, v
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c, n, z, v
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
//   Performs W-bit (W = 4*NIBBLES) ALU operations by running one 4-bit
//   add/sub/logic slice per clock, LSB nibble first, chaining carry.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      alu_nibble_seq_if.slave: start/op/a/b in,
//              busy/done/result/c/n/z/v out (all outputs registered)
//   op: 000 ~a, 001 ~b, 010 a&b, 011 a|b, 100 a^b, 101 ~(a^b), 110 a+b, 111 a-b
//   Optional build macro ALU_SEQ_FAST_LOGIC_EN: logic ops (000-101) complete
//   at the accepting edge without entering RUN; add/sub are unaffected.
module alu_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input logic             clk,
  input logic             reset_n,
  alu_nibble_seq_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state, state_nxt;
  logic           accept, finish;

  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           zacc;
  logic [W-1:0]   work;

  logic [W-1:0]   result_q;
  logic           done_q, c_q, n_q, z_q, v_q;

  logic           is_arith, is_sub, last;
  logic [3:0]     sa, sb, sbx, nib;
  logic [4:0]     sum5;
  logic           cin3;
  logic [W-1:0]   work_nxt;

  function automatic logic [3:0] logic_nib(input logic [2:0] f,
                                           input logic [3:0] x,
                                           input logic [3:0] y);
    case (f)
      3'b000:  return ~x;
      3'b001:  return ~y;
      3'b010:  return x & y;
      3'b011:  return x | y;
      3'b100:  return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  // One nibble of the current operation.
  always_comb begin
    is_arith = op_q[2] & op_q[1];
    is_sub   = (op_q == 3'b111);
    last     = (cnt == CW'(NIBBLES - 1));
    sa       = a_q[{cnt, 2'b00} +: 4];
    sb       = b_q[{cnt, 2'b00} +: 4];
    sbx      = is_sub ? ~sb : sb;
    sum5     = {1'b0, sa} + {1'b0, sbx} + {4'b0000, carry};
    // Carry into the nibble's top bit, recovered from its sum bit.
    cin3     = sa[3] ^ sbx[3] ^ sum5[3];
    nib      = is_arith ? sum5[3:0] : logic_nib(op_q, sa, sb);
    work_nxt = work;
    work_nxt[{cnt, 2'b00} +: 4] = nib;
  end

`ifdef ALU_SEQ_FAST_LOGIC_EN
  logic [W-1:0] fast_w;
  logic         req_logic;

  always_comb begin
    fast_w    = '0;
    req_logic = !(bus.op[2] & bus.op[1]);
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      fast_w[4*i +: 4] = logic_nib(bus.op, bus.a[4*i +: 4], bus.b[4*i +: 4]);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
`ifdef ALU_SEQ_FAST_LOGIC_EN
          state_nxt = req_logic ? IDLE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (last) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      zacc     <= 1'b0;
      work     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q  <= bus.op;
        a_q   <= bus.a;
        b_q   <= bus.b;
        cnt   <= '0;
        carry <= (bus.op == 3'b111);
        zacc  <= 1'b1;
        work  <= '0;
`ifdef ALU_SEQ_FAST_LOGIC_EN
        if (req_logic) begin
          result_q <= fast_w;
          c_q      <= 1'b0;
          v_q      <= 1'b0;
          n_q      <= fast_w[W-1];
          z_q      <= (fast_w == '0);
          done_q   <= 1'b1;
        end
`endif
      end else if (state == RUN) begin
        cnt   <= finish ? '0 : cnt + CW'(1);
        carry <= sum5[4];
        zacc  <= zacc & (nib == 4'h0);
        work  <= work_nxt;
        // Visible result/flags change only here; during RUN they hold.
        if (finish) begin
          result_q <= work_nxt;
          c_q      <= is_arith & sum5[4];
          v_q      <= is_arith & (cin3 ^ sum5[4]);
          n_q      <= work_nxt[W-1];
          z_q      <= zacc & (nib == 4'h0);
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.c      = c_q;
  assign bus.n      = n_q;
  assign bus.z      = z_q;
  assign bus.v      = v_q;
endmodule
